condlogic_it: RTL and testbench
===============================

// Module: condlogic_it
// PURPOSE
//  Parametrised successor to the multi-cycle condition logic. Holds the flag register in NGROUPS
//  independently written groups and gates PC/register/memory writes on the condition result.
//  Adds an IT-style predication sequencer (up to ITDEPTH following instructions, each then/else).
//  Adds a shadow flag register with save/restore for exception entry and return.
//  Sits between the main decoder/control FSM and the datapath enables.
// PARAMETERS
//  NFLAGS  4  flag bits; bits [3:0] = {N,Z,C,V}; any upper bits are stored but never tested; must be >=4
//  NGROUPS 2  flag write groups; GRPW = NFLAGS/NGROUPS; group g = Flags[g*GRPW +: GRPW]
//  ITDEPTH 4  max instructions covered by one IT block; LW = $clog2(ITDEPTH+1)
// PORTS
//  clk         in  1        clock, rising edge
//  reset       in  1        asynchronous, active-low reset
//  Cond        in  4        instruction condition field (ARM encoding)
//  ALUFlags    in  NFLAGS   flags produced by ALU this cycle
//  FlagW       in  NGROUPS  per-group flag write request
//  PCS         in  1        instruction writes PC
//  NextPC      in  1        FSM unconditional PC update (fetch)
//  RegW        in  1        FSM register write request
//  MemW        in  1        FSM memory write request
//  InstrDone   in  1        one-cycle pulse at last state of each instruction
//  ITStart     in  1        IT instruction executing: load IT state
//  ITCond      in  4        IT base condition
//  ITLen       in  LW       number of predicated instructions (1..ITDEPTH)
//  ITPattern   in  ITDEPTH  bit i=1: instr i uses ITCond; 0: uses inverse (ITCond^4'b0001)
//  FlagSave    in  1        copy Flags into SavedFlags
//  FlagRestore in  1        load Flags from SavedFlags, abort IT block
//  PCWrite     out 1        NextPC | (PCS & CondExReg)
//  RegWrite    out 1        RegW & CondExReg
//  MemWrite    out 1        MemW & CondExReg
//  CondEx      out 1        combinational condition result for EffCond vs current Flags
//  Flags       out NFLAGS   architectural flag register
//  InIT        out 1        IT block active
//  ITErr       out 1        one-cycle pulse: illegal IT request
// BEHAVIOUR
//  - Reset (reset=0, async): Flags, SavedFlags, CondExReg, IT count/pattern/cond, ITErr all 0
//    => RegWrite=MemWrite=0, PCWrite=NextPC, InIT=0.
//  - EffCond = InIT ? (pat[0] ? itc : itc^4'b0001) : Cond.
//    CondEx is the standard ARM condcheck of EffCond on Flags[3:0]; 4'b1111 evaluates 0.
//  - Group g loads ALUFlags group g at posedge iff FlagW[g] & CondEx & ~FlagRestore.
//  - CondExReg <= CondEx every cycle; the write enables use the value from the previous cycle
//    (one-cycle latency, matching the FSM ALU->WB ordering).
//  - IT FSM, 2 states: IDLE (InIT=0), ACTIVE (InIT=1, cnt>0).
//    IDLE & ITStart & legal: itc<=ITCond, pat<=ITPattern, cnt<=ITLen, go ACTIVE;
//      InstrDone in the same cycle is ignored.
//    Legal = 1<=ITLen<=ITDEPTH, ITCond!=4'b1111, and not (ITCond==AL with any else bit in use).
//    Illegal ITStart: ITErr=1 next cycle only, no load.
//    ACTIVE & InstrDone: cnt<=cnt-1, pat<=pat>>1; when cnt reaches 0, go IDLE.
//    ACTIVE & ITStart: ignored, ITErr pulses; a coincident InstrDone is still applied.
//  - FlagSave: SavedFlags<=Flags (pre-update value if an ALU write happens the same cycle).
//  - FlagRestore: Flags<=SavedFlags (wins over ALU writes); IT state cleared to IDLE.
//  - FlagSave & FlagRestore together = swap.
//  - Reset asserted mid-IT or mid-instruction clears all state immediately; no partial writes persist.
// TESTING
//  1 reset; Cond=AL, FlagW=2'b11, ALUFlags=4'b0100 -> Flags=0100 next edge; then Cond=EQ, RegW=1 -> CondEx=1, RegWrite=1 following cycle
//  2 Flags=0000, Cond=AL, FlagW=2'b01, ALUFlags=4'b1111 -> Flags=0011; Cond=NE(0001) with Z=1 -> CondEx=0, MemWrite=0
//  3 Z=1, ITStart ITCond=EQ ITLen=3 ITPattern=3'b101, three InstrDone pulses -> CondEx 1,0,1; InIT=0 after third
//  4 ITStart ITLen=0 -> ITErr=1 one cycle, InIT=0; ITStart while InIT -> ITErr=1, cnt unchanged
//  5 Flags=1010, Saved=0101, FlagSave+FlagRestore -> Flags=0101, Saved=1010; FlagRestore mid-IT -> InIT=0
//  6 reset driven low between edges during IT block -> InIT, Flags, RegWrite 0 immediately; PCWrite follows NextPC

Source files
------------

// File: rtl/condlogic_it.sv
// condlogic_it: condition logic with grouped flag writes, IT-style predication and shadow flags.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   Cond              instruction condition field (ARM encoding)
//   ALUFlags, FlagW   ALU flag result and per-group flag write requests
//   PCS, NextPC       PC-writing instruction / unconditional fetch update
//   RegW, MemW        FSM register / memory write requests
//   InstrDone         pulse at the last state of each instruction
//   ITStart, ITCond,  IT instruction: base condition, covered length and
//   ITLen, ITPattern  then/else pattern (bit i=1 -> then)
//   FlagSave          copy Flags into the shadow register
//   FlagRestore       reload Flags from the shadow register, abort any IT block
//   PCWrite, RegWrite,
//   MemWrite          condition-gated datapath enables
//   CondEx            combinational condition result for the effective condition
//   Flags             architectural flags ({N,Z,C,V} in [3:0])
//   InIT, ITErr       IT block active / one-cycle illegal IT request pulse
module condlogic_it #(
    parameter int unsigned NFLAGS  = 4,
    parameter int unsigned NGROUPS = 2,
    parameter int unsigned ITDEPTH = 4,
    localparam int unsigned LW     = $clog2(ITDEPTH + 1),
    localparam int unsigned GRPW   = NFLAGS / NGROUPS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [NFLAGS-1:0]  ALUFlags,
    input  logic [NGROUPS-1:0] FlagW,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               InstrDone,
    input  logic               ITStart,
    input  logic [3:0]         ITCond,
    input  logic [LW-1:0]      ITLen,
    input  logic [ITDEPTH-1:0] ITPattern,
    input  logic               FlagSave,
    input  logic               FlagRestore,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               CondEx,
    output logic [NFLAGS-1:0]  Flags,
    output logic               InIT,
    output logic               ITErr
);

    typedef enum logic [0:0] {StIdle, StActive} it_state_e;

    it_state_e          state_q, state_d;
    logic [NFLAGS-1:0]  flags_q, flags_d;
    logic [NFLAGS-1:0]  saved_q, saved_d;
    logic               condexreg_q;
    logic [LW-1:0]      cnt_q, cnt_d;
    logic [ITDEPTH-1:0] pat_q, pat_d;
    logic [3:0]         itc_q, itc_d;
    logic               iterr_q, iterr_d;

    logic [3:0] effcond;
    logic       n, z, c, v;
    logic       base;
    logic       condex;
    logic       else_used;
    logic       legal;

    // Inside an IT block the condition comes from the IT state; the else slot
    // flips the LSB, which inverts any ARM condition.
    assign effcond = (state_q == StActive) ? (pat_q[0] ? itc_q : (itc_q ^ 4'b0001)) : Cond;

    assign {n, z, c, v} = flags_q[3:0];

    // Even encodings select the base test, odd encodings its inverse.
    always_comb begin
        base = 1'b1;
        case (effcond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        condex = (effcond == 4'b1111) ? 1'b0 : (base ^ effcond[0]);
    end

    // An AL-based IT block cannot have an else slot (its inverse would be NV).
    always_comb begin
        else_used = 1'b0;
        for (int unsigned i = 0; i < ITDEPTH; i++) begin
            if ((i < 32'(ITLen)) && !ITPattern[i]) else_used = 1'b1;
        end
        legal = (ITLen != '0) && (32'(ITLen) <= ITDEPTH) && (ITCond != 4'b1111) &&
                !((ITCond == 4'b1110) && else_used);
    end

    always_comb begin
        flags_d = flags_q;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            if (FlagW[g] && condex) flags_d[g*GRPW +: GRPW] = ALUFlags[g*GRPW +: GRPW];
        end
        if (FlagRestore) flags_d = saved_q;
        // Old value is captured, so save + restore in one cycle swaps.
        saved_d = FlagSave ? flags_q : saved_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        itc_d   = itc_q;
        iterr_d = ITStart & ((state_q == StActive) | ~legal);
        if (FlagRestore) begin
            state_d = StIdle;
            cnt_d   = '0;
            pat_d   = '0;
            itc_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ITStart && legal) begin
                        state_d = StActive;
                        cnt_d   = ITLen;
                        pat_d   = ITPattern;
                        itc_d   = ITCond;
                    end
                end
                StActive: begin
                    if (InstrDone) begin
                        cnt_d = cnt_q - LW'(1);
                        pat_d = pat_q >> 1;
                        if (cnt_q == LW'(1)) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            flags_q     <= '0;
            saved_q     <= '0;
            condexreg_q <= 1'b0;
            cnt_q       <= '0;
            pat_q       <= '0;
            itc_q       <= '0;
            iterr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            saved_q     <= saved_d;
            condexreg_q <= condex;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            itc_q       <= itc_d;
            iterr_q     <= iterr_d;
        end
    end

    assign PCWrite  = NextPC | (PCS & condexreg_q);
    assign RegWrite = RegW & condexreg_q;
    assign MemWrite = MemW & condexreg_q;
    assign CondEx   = condex;
    assign Flags    = flags_q;
    assign InIT     = (state_q == StActive);
    assign ITErr    = iterr_q;

endmodule

// File: tb/tb_condlogic_it.sv
module tb_condlogic_it;

    localparam int unsigned NFLAGS  = 4;
    localparam int unsigned NGROUPS = 2;
    localparam int unsigned ITDEPTH = 4;
    localparam int unsigned LW      = $clog2(ITDEPTH + 1);
    localparam int unsigned GRPW    = NFLAGS / NGROUPS;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         Cond;
    logic [NFLAGS-1:0]  ALUFlags;
    logic [NGROUPS-1:0] FlagW;
    logic               PCS, NextPC, RegW, MemW, InstrDone;
    logic               ITStart;
    logic [3:0]         ITCond;
    logic [LW-1:0]      ITLen;
    logic [ITDEPTH-1:0] ITPattern;
    logic               FlagSave, FlagRestore;
    logic               PCWrite, RegWrite, MemWrite, CondEx, InIT, ITErr;
    logic [NFLAGS-1:0]  Flags;

    condlogic_it #(.NFLAGS(NFLAGS), .NGROUPS(NGROUPS), .ITDEPTH(ITDEPTH)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .InstrDone(InstrDone),
        .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITPattern(ITPattern),
        .FlagSave(FlagSave), .FlagRestore(FlagRestore), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .InIT(InIT), .ITErr(ITErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              pcw;
        logic              rw;
        logic              mw;
        logic              cx;
        logic [NFLAGS-1:0] fl;
        logic              init;
        logic              iterr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: IT block held as a queue of per-instruction conditions.
    logic [NFLAGS-1:0] m_flags, m_saved;
    logic              m_cxr, m_iterr;
    logic [3:0]        m_it[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic arm_cond(input logic [3:0] c, input logic [3:0] f);
        logic nn, zz, cc, vv;
        {nn, zz, cc, vv} = f;
        case (c)
            4'd0:  return zz;
            4'd1:  return !zz;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return nn;
            4'd5:  return !nn;
            4'd6:  return vv;
            4'd7:  return !vv;
            4'd8:  return cc && !zz;
            4'd9:  return !cc || zz;
            4'd10: return nn == vv;
            4'd11: return nn != vv;
            4'd12: return !zz && (nn == vv);
            4'd13: return zz || (nn != vv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit it_legal();
        int len = int'(ITLen);
        if (len < 1 || len > int'(ITDEPTH) || ITCond == 4'd15) return 0;
        if (ITCond == 4'd14)
            for (int i = 0; i < len; i++) if (!ITPattern[i]) return 0;
        return 1;
    endfunction

    function automatic logic cur_condex();
        logic [3:0] ec = (m_it.size() > 0) ? m_it[0] : Cond;
        return arm_cond(ec, m_flags[3:0]);
    endfunction

    task automatic model_clear();
        m_flags = '0;
        m_saved = '0;
        m_cxr   = 1'b0;
        m_iterr = 1'b0;
        m_it.delete();
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.cx    = cur_condex();
        e.pcw   = NextPC | (PCS & m_cxr);
        e.rw    = RegW & m_cxr;
        e.mw    = MemW & m_cxr;
        e.fl    = m_flags;
        e.init  = (m_it.size() > 0);
        e.iterr = m_iterr;
        return e;
    endfunction

    task automatic model_step();
        logic              cx;
        logic [NFLAGS-1:0] nf;
        bit                act;
        if (!reset) begin
            model_clear();
            return;
        end
        act = (m_it.size() > 0);
        cx  = cur_condex();
        nf  = m_flags;
        for (int g = 0; g < int'(NGROUPS); g++)
            if (FlagW[g] && cx)
                for (int b = 0; b < int'(GRPW); b++) nf[g*GRPW+b] = ALUFlags[g*GRPW+b];
        if (FlagRestore) nf = m_saved;
        if (FlagSave) m_saved = m_flags;
        m_flags = nf;
        m_cxr   = cx;
        m_iterr = ITStart && (act || !it_legal());
        if (FlagRestore) m_it.delete();
        else if (act) begin
            if (InstrDone) void'(m_it.pop_front());
        end else if (ITStart && it_legal()) begin
            for (int i = 0; i < int'(ITLen); i++)
                m_it.push_back(ITPattern[i] ? ITCond : (ITCond ^ 4'b0001));
        end
    endtask

    // One cycle: inputs already set by the caller; returns 1 time unit after the edge.
    task automatic drive();
        #1;
        if (!reset) model_clear();
        sb_q.push_back(model_outputs());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b1; Cond = 4'd14; ALUFlags = '0; FlagW = '0;
        PCS = 0; NextPC = 0; RegW = 0; MemW = 0; InstrDone = 0;
        ITStart = 0; ITCond = 4'd0; ITLen = '0; ITPattern = '0;
        FlagSave = 0; FlagRestore = 0;
    endtask

    task automatic set_flags(input logic [NFLAGS-1:0] f);
        idle_inputs();
        FlagW = '1; ALUFlags = f;
        drive();
        idle_inputs();
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_pcwrite",  PCWrite,  e.pcw);
            chk("sb_regwrite", RegWrite, e.rw);
            chk("sb_memwrite", MemWrite, e.mw);
            chk("sb_condex",   CondEx,   e.cx);
            chk("sb_flags",    Flags,    e.fl);
            chk("sb_init",     InIT,     e.init);
            chk("sb_iterr",    ITErr,    e.iterr);
        end
    end

    initial begin
        logic [2:0] t3_exp;
        idle_inputs();
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;

        // 1: reset, AL flag write, then EQ gated register write
        drive(); drive();
        chk("t1_reset_flags", Flags, 0);
        chk("t1_reset_init", InIT, 0);
        idle_inputs();
        FlagW = 2'b11; ALUFlags = 4'b0100;
        drive();
        chk("t1_flags", Flags, 4'b0100);
        Cond = 4'd0; FlagW = '0; RegW = 1;
        drive();
        chk("t1_regwrite", RegWrite, 1);

        // 2: single-group write, NE with Z=1
        set_flags(4'b0000);
        FlagW = 2'b01; ALUFlags = 4'b1111;
        drive();
        chk("t2_group0", Flags, 4'b0011);
        FlagW = 2'b10; ALUFlags = 4'b0100;
        drive();
        chk("t2_group1", Flags, 4'b0111);
        idle_inputs();
        Cond = 4'd1; MemW = 1;
        #1;
        chk("t2_condex", CondEx, 0);
        drive();
        chk("t2_memwrite", MemWrite, 0);

        // 3: IT EQ, length 3, pattern then/else/then
        set_flags(4'b0100);
        ITStart = 1; ITCond = 4'd0; ITLen = LW'(3); ITPattern = 4'b0101;
        drive();
        chk("t3_init", InIT, 1);
        t3_exp = 3'b101;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            InstrDone = 1;
            #1;
            chk("t3_condex", CondEx, t3_exp[i]);
            drive();
        end
        chk("t3_done", InIT, 0);

        // 4: illegal length, then ITStart while active
        idle_inputs();
        ITStart = 1; ITLen = '0;
        drive();
        chk("t4_err_len", ITErr, 1);
        chk("t4_init_len", InIT, 0);
        idle_inputs();
        drive();
        chk("t4_err_clear", ITErr, 0);
        ITStart = 1; ITCond = 4'd0; ITLen = LW'(2); ITPattern = 4'b0011;
        drive();
        chk("t4_start_ok", ITErr, 0);
        drive();
        chk("t4_err_active", ITErr, 1);
        chk("t4_still_in", InIT, 1);
        idle_inputs();
        InstrDone = 1;
        drive();
        chk("t4_cnt_one", InIT, 1);
        drive();
        chk("t4_cnt_zero", InIT, 0);

        // 5: save/restore swap, restore mid-IT
        set_flags(4'b0101);
        FlagSave = 1;
        drive();
        set_flags(4'b1010);
        FlagSave = 1; FlagRestore = 1;
        drive();
        chk("t5_swap_flags", Flags, 4'b0101);
        idle_inputs();
        FlagRestore = 1;
        drive();
        chk("t5_swap_saved", Flags, 4'b1010);
        idle_inputs();
        ITStart = 1; ITLen = LW'(4); ITPattern = 4'b1111;
        drive();
        chk("t5_it_on", InIT, 1);
        idle_inputs();
        FlagRestore = 1;
        drive();
        chk("t5_it_abort", InIT, 0);

        // 6: asynchronous reset mid-IT
        set_flags(4'b0100);
        ITStart = 1; ITLen = LW'(4); ITPattern = 4'b1111; RegW = 1;
        drive();
        chk("t6_pre_regwrite", RegWrite, 1);
        chk("t6_pre_init", InIT, 1);
        idle_inputs();
        RegW = 1; NextPC = 1; reset = 0;
        #1;
        chk("t6_init", InIT, 0);
        chk("t6_flags", Flags, 0);
        chk("t6_regwrite", RegWrite, 0);
        chk("t6_pcwrite", PCWrite, 1);
        drive();

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            reset       = ($urandom_range(0, 99) >= 2);
            Cond        = 4'($urandom_range(0, 15));
            ALUFlags    = NFLAGS'($urandom);
            FlagW       = NGROUPS'($urandom);
            PCS         = 1'($urandom);
            NextPC      = 1'($urandom);
            RegW        = 1'($urandom);
            MemW        = 1'($urandom);
            InstrDone   = 1'($urandom);
            ITStart     = ($urandom_range(0, 99) < 15);
            ITCond      = 4'($urandom_range(0, 15));
            ITLen       = LW'($urandom_range(0, 5));
            ITPattern   = ITDEPTH'($urandom);
            FlagSave    = ($urandom_range(0, 99) < 6);
            FlagRestore = ($urandom_range(0, 99) < 5);
            drive();
        end

        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
